// File: rtl/shared_imem.sv
// Instruction memory shared by NUM_CORES fetch ports through one single-ported RAM.
// Round-robin arbitration, 1-cycle registered read, run-time program-load port.
module shared_imem #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 1024,
    parameter int                NUM_CORES = 4,
    parameter logic [DATA_W-1:0] OOR_DATA  = DATA_W'(43)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr,
    output logic [NUM_CORES-1:0]          gnt,
    output logic [NUM_CORES*DATA_W-1:0]   rdata,
    output logic [NUM_CORES-1:0]          rvalid,
    input  logic                          load_en,
    input  logic [ADDR_W-1:0]             load_addr,
    input  logic [DATA_W-1:0]             load_data,
    output logic                          busy
);

    localparam int              PTR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]           mem_q [DEPTH];
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [NUM_CORES-1:0]        rvalid_q, rvalid_d;
    logic [NUM_CORES*DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_CORES-1:0]        gnt_d;
    logic                        gnt_any;
    logic [PTR_W-1:0]            gnt_idx;
    int                          cand;
    logic [ADDR_W-1:0]           sel_addr;
    logic                        sel_in_range;
    logic                        load_in_range;
    logic [DATA_W-1:0]           rd_word;

    // Arbiter: first requester at or after the pointer, suppressed while loading.
    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        gnt_d   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        if (!load_en) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                cand = (int'(ptr_q) + i) % NUM_CORES;
                if (!gnt_any && req[cand]) begin
                    gnt_d[cand] = 1'b1;
                    gnt_any     = 1'b1;
                    gnt_idx     = PTR_W'(cand);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = PTR_W'((int'(gnt_idx) + 1) % NUM_CORES);
        end
    end

    // Out-of-range fetches bypass the array and return the halt opcode.
    always_comb begin
        sel_addr     = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_in_range = ({1'b0, sel_addr} < DEPTH_LIM);
        rd_word      = sel_in_range ? mem_q[sel_addr[MEM_AW-1:0]] : OOR_DATA;
    end

    always_comb begin
        rvalid_d = gnt_d;
        rdata_d  = rdata_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt_d[i]) begin
                rdata_d[i*DATA_W +: DATA_W] = rd_word;
            end
        end
    end

    assign load_in_range = ({1'b0, load_addr} < DEPTH_LIM);

    // NOTE: the RAM array has no reset; program contents survive rst_n and need no reset fan-out.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem_q[load_addr[MEM_AW-1:0]] <= load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gnt    = gnt_d;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign busy   = load_en | (|(req & ~gnt_d));

endmodule

// File: doc/shared_imem.md
Name: shared_imem

Overview:
- Parametrised instruction memory shared by NUM_CORES processor cores through one single-ported RAM array.
- Per-core request/grant read ports, resolved by a round-robin arbiter; each granted read returns data one cycle later.
- Adds a program-load write port so contents are written at run time rather than fixed at elaboration.
- Out-of-range fetches return a configurable opcode, so a core fetching past the program end halts cleanly.

Parameters:
- DATA_W, 16, instruction/operand word width
- ADDR_W, 16, per-core address width
- DEPTH, 1024, number of words stored; valid addresses are 0..DEPTH-1
- NUM_CORES, 4, number of fetch ports (>=1)
- OOR_DATA, 43, word returned for addresses >= DEPTH (ENDOP encoding)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_CORES  per-core fetch request, held until granted
- addr  in  NUM_CORES*ADDR_W  per-core fetch address, core i at bits [i*ADDR_W +: ADDR_W], stable while req high
- gnt  out  NUM_CORES  one-hot, combinational grant for the current cycle
- rdata  out  NUM_CORES*DATA_W  per-core read data, same slicing as addr
- rvalid  out  NUM_CORES  one-cycle pulse: rdata slice of that core is valid
- load_en  in  1  program-load write strobe
- load_addr  in  ADDR_W  load write address
- load_data  in  DATA_W  load write data
- busy  out  1  high when load_en is high or any req is pending but not granted this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - rvalid=0, rdata=0 for all cores.
  - Round-robin pointer = 0 (core 0 has highest priority).
  - RAM contents are not cleared.
- Arbitration:
  - Combinational. Among asserted req bits, gnt selects the first core at or after the pointer, wrapping modulo NUM_CORES.
  - gnt=0 if no req is asserted or load_en=1.
  - At most one gnt bit is high per cycle.
- Pointer update: on a cycle with a grant to core k, the pointer becomes (k+1) mod NUM_CORES. With no grant, the pointer holds.
- Read:
  - On the grant cycle, the RAM word at addr[k] is registered into rdata slice k.
  - If addr[k] >= DEPTH, OOR_DATA is registered instead; the RAM is not accessed.
  - rvalid[k]=1 on the next cycle only; fixed 1-cycle latency.
  - Other cores' rdata slices hold their last values; their rvalid bits are 0.
- Handshake:
  - A core keeps req and addr stable until it sees gnt.
  - It may drop req, or present a new addr with req high, in the cycle after the grant.
  - Back-to-back grants to the same core are allowed only when it is the sole requester.
- Load:
  - When load_en=1, load_data is written at load_addr on the rising edge. Writes with load_addr >= DEPTH are discarded.
  - Load has absolute priority: no grant is issued that cycle and the pointer holds.
  - A read granted in the previous cycle still completes: its rvalid is unaffected.
- Read/write ordering: a read granted on the cycle right after a load to the same address returns the newly loaded word.
- Fairness: with all NUM_CORES requesting continuously and no load, each core is granted exactly once every NUM_CORES cycles.
- Reset mid-operation: a pending rvalid is cancelled (forced 0 immediately). Cores must re-request after reset.
- NUM_CORES=1: the arbiter degenerates to gnt=req & ~load_en; the pointer stays 0.

Test Plan:
- Load word 16'd34 at address 5, then core 2 alone requests addr 5 → gnt=4'b0100 that cycle; next cycle rvalid=4'b0100, rdata[2]=16'd34.
- All 4 cores request continuously for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3; each rvalid pulse arrives 1 cycle after its grant.
- Cores 1 and 3 request while load_en=1 for 2 cycles → gnt=0 and busy=1 for both cycles; core 1 is granted on the first cycle after load_en drops, core 3 on the next.
- Core 0 requests addr 1024 (DEPTH=1024) → rdata[0]=16'd43 with rvalid[0]=1 one cycle after the grant. A load to addr 1030 leaves addresses 0..1023 unchanged.
- Core 3 is granted, then rst_n is pulsed low before the next edge → rvalid=0 and rdata=0 immediately. After release, core 0 wins first when cores 0 and 3 both request.
- Load addr 7 = 16'd28, then core 1 requests addr 7 on the following cycle → rdata[1]=16'd28.
